// File: rtl/dtmf_digit_fifo_if.sv
// Host read port of the digit FIFO: valid/ready handshake with head-of-queue data.
// master = FIFO side (drives valid/data), slave = host side (drives ready).
interface dtmf_digit_fifo_if #(
    parameter int DWIDTH = 8
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DWIDTH-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/dtmf_digit_fifo.sv
// Re-timed digit capture into a FWFT FIFO; entry visible 3 clk edges after flag_in rises.
// Backpressure: host valid/ready read port; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module dtmf_digit_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int THRESH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] digit_in,
    input  logic              flag_in,
    input  logic              ovf_clr,
    dtmf_digit_fifo_if.master rd,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              irq
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

    logic              flag_s1;
    logic              flag_s2;
    logic              flag_s3;
    logic [DWIDTH-1:0] dig_s1;
    logic [DWIDTH-1:0] dig_s2;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DWIDTH-1:0] mem [DEPTH];

    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    // digit_in is held stable while flag_in is high, so the data sync only
    // needs to match the flag's two-stage delay to land on the push cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_s1 <= 1'b0;
            flag_s2 <= 1'b0;
            flag_s3 <= 1'b0;
            dig_s1  <= '0;
            dig_s2  <= '0;
        end else begin
            flag_s1 <= flag_in;
            flag_s2 <= flag_s1;
            flag_s3 <= flag_s2;
            dig_s1  <= digit_in;
            dig_s2  <= dig_s1;
        end
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign push  = flag_s2 & ~flag_s3;
    assign pop   = rd.rd_valid & rd.rd_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh drop outranks a clear arriving in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= dig_s2;
        end
    end

    assign rd.rd_valid = ~empty;
    assign rd.rd_data  = mem[rptr];
    assign irq         = (count >= THRESH_C);

endmodule
